shiftreg_univ: RTL and testbench
================================

# shiftreg_univ

Parametrised universal shift register: the successor to the fixed 4-bit serial-in/parallel-out register. It supports configurable width, left/right shift direction, synchronous parallel load, serial output, and a bit counter with a word-complete strobe. An optional snapshot stage captures each completed word and hands it to a downstream consumer over a valid/ack handshake. It sits between a serial bit source and word-oriented logic, and can also serialise a loaded word out.

## Interface
- `WIDTH`, 8 — register width in bits; must be ≥ 2.
- `RESET_VAL`, 0 — value of `q` after reset; `WIDTH` bits.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state immediately.
- `en`  in  1  — shift enable.
- `dir`  in  1  — 0 = shift left (toward MSB), 1 = shift right (toward LSB).
- `x`  in  1  — serial input bit.
- `load`  in  1  — synchronous parallel load.
- `d`  in  `WIDTH`  — parallel load data.
- `q`  out  `WIDTH`  — register contents.
- `sout`  out  1  — serial output: `q[WIDTH-1]` when `dir`=0, `q[0]` when `dir`=1 (combinational on `dir`).
- `bit_cnt`  out  `$clog2(WIDTH)`  — bits shifted since the last reset, load, or word boundary.
- `word_done`  out  1  — one-cycle pulse; `q` holds `WIDTH` freshly shifted bits.
- `word_q`  out  `WIDTH`  — snapshot of the completed word.
- `word_valid`  out  1  — `word_q` holds an unconsumed word.
- `word_ack`  in  1  — consumer accepts `word_q`.
- `overrun`  out  1  — sticky: a completed word was dropped.

## Operation
- Reset values:
  - `q` = `RESET_VAL`.
  - `bit_cnt`, `word_done`, `word_q`, `word_valid`, `overrun` = 0.
- Priority per edge: `load` > `en` shift > hold.
- `load`=1:
  - `q` ← `d`; `bit_cnt` ← 0; `word_done` ← 0.
  - `en` and `x` are ignored that cycle.
- `en`=1, `load`=0:
  - `dir`=0: `q` ← {`q[WIDTH-2:0]`, `x`}.
  - `dir`=1: `q` ← {`x`, `q[WIDTH-1:1]`}.
  - If `bit_cnt` = `WIDTH`-1: `bit_cnt` ← 0 (wrap) and `word_done` ← 1. Otherwise `bit_cnt` increments and `word_done` ← 0.
- `en`=0, `load`=0: all of `q` and `bit_cnt` hold; `word_done` ← 0.
- Changing `dir` mid-word does not reset `bit_cnt`; the count spans both directions.
- Continuous shifting with `en` held high produces `word_done` every `WIDTH` cycles, with no gap.

## Timing
- Shift latency: a bit presented on `x` at edge N appears in `q` after edge N.
- `word_done` rises after the same edge as the `WIDTH`-th shift and is high for exactly one cycle.
- `sout` reflects `q` with zero added latency.
- Async `reset` mid-word: all outputs take their reset values immediately.
  - The partial word is discarded.
  - Counting restarts at 0 on the first shift after `reset` deasserts.

## Configuration
- With `SHIFTREG_SNAPSHOT_EN` defined:
  - The edge that sets `word_done` also captures the new `q` into `word_q` and sets `word_valid`.
  - `word_valid` stays high until an edge with `word_ack`=1, then clears.
  - If a new word completes while `word_valid`=1 and `word_ack`=0: `word_q` is kept, the new word is dropped, and `overrun` ← 1. `overrun` clears only on reset.
  - Simultaneous completion and `word_ack`=1: `word_q` ← new word, `word_valid` stays 1, no overrun.
  - `word_ack` while `word_valid`=0 is ignored.
- Without `SHIFTREG_SNAPSHOT_EN`:
  - The ports remain; `word_q`, `word_valid`, `overrun` are constant 0 and `word_ack` is ignored.

## Test plan
- Reset, `WIDTH`=4, `RESET_VAL`=4'hA: `q`=4'hA, `bit_cnt`=0, all flags 0; assert `reset` mid-word at `bit_cnt`=2 → `q`=4'hA immediately, next word needs 4 full shifts.
- `dir`=0, `en`=1, shift `x`=1,1,0,1 → `q`=4'b1101 and `word_done` high for exactly 1 cycle after the 4th edge; continue shifting 0,1,1,0 → `q`=4'b0110, second pulse exactly 4 cycles later.
- `dir`=1, shift 1,0,0,0 from `q`=0 → `q`=4'b0001; `sout` equals `q[0]` each cycle.
- `load`=1 with `d`=4'hC and `en`=1 on the same edge at `bit_cnt`=3 → `q`=4'hC, `bit_cnt`=0, no `word_done`; then 4 right shifts of `x`=0 → `sout` sequence 0,0,1,1.
- `SHIFTREG_SNAPSHOT_EN`: complete word 4'h5 with `word_ack`=0 → `word_q`=4'h5, `word_valid`=1; complete 4'h9 without ack → `word_q` stays 4'h5, `overrun`=1; ack on the same edge as the next completion 4'h3 → `word_q`=4'h3, `word_valid`=1.
- Without the macro: same stimulus → `word_q`/`word_valid`/`overrun` constant 0, `word_done` pulses unchanged.

Source files
------------

// File: rtl/shiftreg_univ.sv
// shiftreg_univ - parametrised universal shift register.
//   Left/right serial shift, synchronous parallel load, serial output,
//   bit counter with a one-cycle word-complete strobe.
//   Optional snapshot stage (define SHIFTREG_SNAPSHOT_EN) captures each
//   completed word into word_q and offers it over a valid/ack handshake,
//   with a sticky overrun flag when a completed word has to be dropped.
//   Without the macro the snapshot ports exist but read as constant 0.
module shiftreg_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     dir,
    input  logic                     x,
    input  logic                     load,
    input  logic [WIDTH-1:0]         d,
    output logic [WIDTH-1:0]         q,
    output logic                     sout,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     word_done,
    output logic [WIDTH-1:0]         word_q,
    output logic                     word_valid,
    input  logic                     word_ack,
    output logic                     overrun
);

    localparam int                CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_shift_q;
    logic             w_shift;
    logic             w_word_end;

    // Shifted value for the current direction; x enters at the far end.
    always_comb begin
        w_shift_q = r_q;
        if (dir)
            w_shift_q = {x, r_q[WIDTH-1:1]};
        else
            w_shift_q = {r_q[WIDTH-2:0], x};
    end

    // Load wins over shift; the WIDTH-th shift since the last boundary ends a word.
    assign w_shift    = en & ~load;
    assign w_word_end = w_shift & (r_cnt == LAST);

    // Data register and bit counter; load restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= RESET_VAL;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (load) begin
            r_q    <= d;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (en) begin
            r_q    <= w_shift_q;
            r_cnt  <= w_word_end ? '0 : r_cnt + 1'b1;
            r_done <= w_word_end;
        end else begin
            r_done <= 1'b0;
        end
    end

`ifdef SHIFTREG_SNAPSHOT_EN
    logic [WIDTH-1:0] r_word_q;
    logic             r_word_valid;
    logic             r_overrun;

    // Snapshot stage: capture when the slot is free or being freed this edge,
    // otherwise keep the held word and flag the drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_q     <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_word_end) begin
            if (!r_word_valid || word_ack) begin
                r_word_q     <= w_shift_q;
                r_word_valid <= 1'b1;
            end else begin
                r_overrun    <= 1'b1;
            end
        end else if (word_ack) begin
            r_word_valid <= 1'b0;
        end
    end

    assign word_q     = r_word_q;
    assign word_valid = r_word_valid;
    assign overrun    = r_overrun;
`else
    logic w_unused_ack;
    assign w_unused_ack = word_ack;
    assign word_q       = '0;
    assign word_valid   = 1'b0;
    assign overrun      = 1'b0;
`endif

    assign q         = r_q;
    assign bit_cnt   = r_cnt;
    assign word_done = r_done;
    assign sout      = dir ? r_q[0] : r_q[WIDTH-1];

endmodule

// File: tb/tb_shiftreg_univ.sv
// tb_shiftreg_univ - self-checking bench for shiftreg_univ (WIDTH=4,
// RESET_VAL=4'hA). Directed table, hand sequences for async reset and the
// snapshot handshake, then randomized traffic against a reference model.
module tb_shiftreg_univ;

    localparam int         W    = 4;
    localparam logic [3:0] RV   = 4'hA;
`ifdef SHIFTREG_SNAPSHOT_EN
    localparam bit         SNAP = 1'b1;
`else
    localparam bit         SNAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         en, dir, x, load, word_ack;
    logic [W-1:0] d;
    logic [W-1:0] q, word_q;
    logic         sout, word_done, word_valid, overrun;
    logic [1:0]   bit_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0] m_q, m_wq;
    int           m_cnt;
    logic         m_done, m_wv, m_ov;

    shiftreg_univ #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .x(x), .load(load),
        .d(d), .q(q), .sout(sout), .bit_cnt(bit_cnt), .word_done(word_done),
        .word_q(word_q), .word_valid(word_valid), .word_ack(word_ack),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, dir, x, load, ack;
        logic [3:0] d;
        logic [3:0] eq;
        int         ecnt;
        logic       edone, esout;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = RV; m_cnt = 0; m_done = 0; m_wq = '0; m_wv = 0; m_ov = 0;
    endtask

    // Behavioural rule set, one clock edge, using the inputs held across it.
    task automatic model_edge();
        bit done_word;
        done_word = 0;
        if (load) begin
            m_q = d; m_cnt = 0; m_done = 0;
        end else if (en) begin
            if (dir) m_q = (m_q >> 1) | (4'(x) << (W - 1));
            else     m_q = (m_q << 1) | 4'(x);
            m_cnt = (m_cnt + 1) % W;
            m_done = (m_cnt == 0);
            done_word = m_done;
        end else begin
            m_done = 0;
        end
        if (SNAP) begin
            if (done_word) begin
                if (!m_wv || word_ack) begin m_wq = m_q; m_wv = 1; end
                else m_ov = 1;
            end else if (word_ack) m_wv = 0;
        end
    endtask

    task automatic drive(input logic e, input logic dr, input logic xi,
                         input logic ld, input logic [3:0] dd, input logic ak);
        en = e; dir = dr; x = xi; load = ld; d = dd; word_ack = ak;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " q"}, int'(q), int'(m_q));
        chk({tag, " bit_cnt"}, int'(bit_cnt), m_cnt);
        chk({tag, " word_done"}, int'(word_done), int'(m_done));
        chk({tag, " sout"}, int'(sout), int'(dir ? m_q[0] : m_q[W-1]));
        chk({tag, " word_q"}, int'(word_q), int'(m_wq));
        chk({tag, " word_valid"}, int'(word_valid), int'(m_wv));
        chk({tag, " overrun"}, int'(overrun), int'(m_ov));
    endtask

    task automatic shift_word(input logic [3:0] bits, input logic ack_last);
        for (int i = 3; i >= 0; i--)
            drive(1, 0, bits[i], 0, 4'h0, (i == 0) ? ack_last : 1'b0);
    endtask

    vec_t tbl[$];

    initial begin
        en = 0; dir = 0; x = 0; load = 0; d = '0; word_ack = 0;
        reset = 1;
        model_reset();
        #12;
        // reset state
        chk("rst q", int'(q), 'hA);
        chk("rst bit_cnt", int'(bit_cnt), 0);
        chk("rst word_done", int'(word_done), 0);
        chk("rst word_q", int'(word_q), 0);
        chk("rst word_valid", int'(word_valid), 0);
        chk("rst overrun", int'(overrun), 0);
        @(negedge clk);
        reset = 0;

        // directed table: {en,dir,x,load,ack,d, q,cnt,done,sout}
        tbl.push_back('{1,0,1,0,0,4'h0, 4'b0101,1,0,0});
        tbl.push_back('{1,0,1,0,0,4'h0, 4'b1011,2,0,1});
        tbl.push_back('{1,0,0,0,0,4'h0, 4'b0110,3,0,0});
        tbl.push_back('{1,0,1,0,0,4'h0, 4'b1101,0,1,1});
        tbl.push_back('{1,0,0,0,0,4'h0, 4'b1010,1,0,1});
        tbl.push_back('{1,0,1,0,0,4'h0, 4'b0101,2,0,0});
        tbl.push_back('{1,0,1,0,0,4'h0, 4'b1011,3,0,1});
        tbl.push_back('{1,0,0,0,0,4'h0, 4'b0110,0,1,0});
        tbl.push_back('{0,0,1,0,0,4'h0, 4'b0110,0,0,0});
        tbl.push_back('{0,1,1,1,0,4'h0, 4'b0000,0,0,0});
        tbl.push_back('{1,1,1,0,0,4'h0, 4'b1000,1,0,0});
        tbl.push_back('{1,1,0,0,0,4'h0, 4'b0100,2,0,0});
        tbl.push_back('{1,1,0,0,0,4'h0, 4'b0010,3,0,0});
        tbl.push_back('{1,1,0,0,0,4'h0, 4'b0001,0,1,1});
        tbl.push_back('{1,1,0,0,0,4'h0, 4'b0000,1,0,0});
        tbl.push_back('{1,0,0,0,0,4'h0, 4'b0000,2,0,0});
        tbl.push_back('{1,1,0,0,0,4'h0, 4'b0000,3,0,0});
        tbl.push_back('{1,1,1,1,0,4'hC, 4'b1100,0,0,0});
        tbl.push_back('{1,1,0,0,0,4'h0, 4'b0110,1,0,0});
        tbl.push_back('{1,1,0,0,0,4'h0, 4'b0011,2,0,1});
        tbl.push_back('{1,1,0,0,0,4'h0, 4'b0001,3,0,1});
        tbl.push_back('{1,1,0,0,0,4'h0, 4'b0000,0,1,0});
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].dir, tbl[i].x, tbl[i].load, tbl[i].d, tbl[i].ack);
            chk($sformatf("tbl%0d q", i), int'(q), int'(tbl[i].eq));
            chk($sformatf("tbl%0d bit_cnt", i), int'(bit_cnt), tbl[i].ecnt);
            chk($sformatf("tbl%0d word_done", i), int'(word_done), int'(tbl[i].edone));
            chk($sformatf("tbl%0d sout", i), int'(sout), int'(tbl[i].esout));
        end

        // async reset mid-word at bit_cnt=2
        drive(1, 0, 1, 0, 4'h0, 0);
        drive(1, 0, 1, 0, 4'h0, 0);
        chk("pre-rst bit_cnt", int'(bit_cnt), 2);
        #2 reset = 1;
        model_reset();
        #1;
        chk("async rst q", int'(q), 'hA);
        chk("async rst bit_cnt", int'(bit_cnt), 0);
        chk("async rst word_valid", int'(word_valid), 0);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 4'h0, 0);
            chk("post-rst no done", int'(word_done), 0);
        end
        drive(1, 0, 0, 0, 4'h0, 0);
        chk("post-rst done on 4th", int'(word_done), 1);

        // snapshot handshake sequence, restart from a clean count
        reset = 1; #1; model_reset(); @(negedge clk); reset = 0;
        shift_word(4'h5, 0);
        chk("snap w5 done", int'(word_done), 1);
        chk("snap w5 word_q", int'(word_q), SNAP ? 5 : 0);
        chk("snap w5 valid", int'(word_valid), SNAP ? 1 : 0);
        shift_word(4'h9, 0);
        chk("snap w9 q", int'(q), 9);
        chk("snap w9 word_q kept", int'(word_q), SNAP ? 5 : 0);
        chk("snap w9 overrun", int'(overrun), SNAP ? 1 : 0);
        shift_word(4'h3, 1);
        chk("snap w3 done", int'(word_done), 1);
        chk("snap w3 word_q", int'(word_q), SNAP ? 3 : 0);
        chk("snap w3 valid", int'(word_valid), SNAP ? 1 : 0);
        drive(0, 0, 0, 0, 4'h0, 1);
        chk("snap ack clears", int'(word_valid), 0);
        chk("snap overrun sticky", int'(overrun), SNAP ? 1 : 0);
        check_model("snap");

        // randomized traffic against the model
        reset = 1; #1; model_reset(); @(negedge clk); reset = 0;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 8), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 19) == 0), 4'($urandom),
                  ($urandom_range(0, 3) == 0));
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
